// File: rtl/ext_pipe.sv
// Immediate extender with a 2-entry output FIFO: result visible the edge after push, no in->out bypass.
// in_ready depends only on occupancy, so downstream stalls never ripple combinationally upstream.
module ext_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHAMT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       occupancy
);

  localparam int PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] zext, sext, ext_val;
  logic [OUT_W-1:0] mem_q [2];
  logic [OUT_W-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  always_comb begin
    zext    = {{PAD_W{1'b0}}, in_imm};
    sext    = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
    ext_val = zext;
    case (in_op)
      2'd0:    ext_val = zext;
      2'd1:    ext_val = sext;
      2'd2:    ext_val = zext << PAD_W;
      default: ext_val = sext << BR_SHAMT;
    endcase
  end

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign occupancy = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Squash wins over any same-cycle transfer.
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = ext_val;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
